kamus_ctrl_fsm: RTL and testbench
=================================

# kamus_ctrl_fsm

Multi-cycle control FSM for the kamus-v core, replacing the purely combinational per-opcode decode with a sequenced controller. It accepts one decoded instruction class at a time over a valid/ready handshake and drives PC-select, writeback-select, L1D request and regfile write strobes across execute, memory-wait, flush and trap phases. It sits between the decoder and the datapath and adds what the combinational version lacks: memory wait states with timeout, parametrised post-redirect flush, and illegal-instruction/timeout trapping.

## Interface
- MEM_TIMEOUT, 16: cycles allowed in MEM without `mem_ack_i` before trapping; legal range ≥2
- FLUSH_CYCLES, 2: cycles `flush_o` is held after any PC redirect; legal range ≥1
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- instr_valid_i  in  1  decoded instruction present
- instr_ready_o  out  1  FSM accepts instruction (IDLE and not in reset)
- op_class_i  in  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5–7 illegal
- branch_taken_i  in  1  branch outcome, sampled with the instruction
- mem_ack_i  in  1  L1D transfer complete
- instr_addr_state_o  out  2  0 PC_ST, 1 B_ST, 2 J_ST, 3 TRAP_ST
- wb_sel_o  out  1  0 ALU_RESULT, 1 MEM_RESULT
- l1d_req_o  out  1  L1D access request
- l1d_wr_en_o  out  1  L1D write (store)
- regfile_wr_en_o  out  1  register file write strobe
- pc_en_o  out  1  PC update strobe
- flush_o  out  1  flush younger pipeline state
- trap_o  out  1  one-cycle trap pulse
- trap_cause_o  out  1  0 illegal op, 1 memory timeout; held until next trap
- state_o  out  3  current state (debug): 0 IDLE, 1 EXEC, 2 MEM, 3 FLUSH, 4 TRAP

## Operation
- States IDLE, EXEC, MEM, FLUSH, TRAP. Accept = `instr_valid_i & instr_ready_o`; on accept latch `op_class_i` and `branch_taken_i`. Valid outside IDLE is ignored.
- IDLE: accept of legal class → EXEC; accept of illegal class → TRAP, cause 0.
- EXEC, by latched class:
  - ALU: `regfile_wr_en_o`=1, `wb_sel_o`=ALU, `pc_en_o`=1, PC_ST → IDLE.
  - JUMP: `regfile_wr_en_o`=1, `wb_sel_o`=ALU, `pc_en_o`=1, J_ST → FLUSH.
  - BRANCH taken: `pc_en_o`=1, B_ST → FLUSH. Not taken: `pc_en_o`=1, PC_ST → IDLE. No regfile write.
  - LOAD/STORE: no strobes → MEM, timeout counter cleared.
- MEM: `l1d_req_o`=1; `l1d_wr_en_o`=1 for STORE only. On `mem_ack_i` (Mealy, same cycle): `pc_en_o`=1, PC_ST; LOAD also `regfile_wr_en_o`=1, `wb_sel_o`=MEM → IDLE. No ack: counter +1; no ack in MEM cycle number MEM_TIMEOUT → TRAP, cause 1. Ack in that last cycle wins over timeout.
- FLUSH: `flush_o`=1 for exactly FLUSH_CYCLES cycles, then IDLE.
- TRAP: one cycle; `trap_o`=1, `flush_o`=1, `pc_en_o`=1, TRAP_ST; `trap_cause_o` updated on entry → FLUSH.
- Outputs not listed for a state are 0; `instr_addr_state_o` defaults PC_ST, `wb_sel_o` ALU. `mem_ack_i` outside MEM is ignored.
- Counter width $clog2(MEM_TIMEOUT+1); flush counter width $clog2(FLUSH_CYCLES+1); no wrap possible.

## Timing
- Reset (async, any state, mid-MEM included): state IDLE, counters 0, `trap_cause_o`=0, all outputs 0 while `rst_i` high, including `instr_ready_o`; `instr_ready_o`=1 in the first cycle after deassertion.
- ALU/not-taken branch: accept at T, strobes at T+1, ready again at T+2.
- JUMP/taken branch: strobes at T+1, flush T+2..T+1+FLUSH_CYCLES, ready at T+2+FLUSH_CYCLES.
- LOAD/STORE with ack in k-th MEM cycle (1≤k≤MEM_TIMEOUT): MEM from T+2, strobes at T+1+k, ready at T+2+k.
- Timeout: MEM T+2..T+1+MEM_TIMEOUT, TRAP at T+2+MEM_TIMEOUT, then FLUSH.
- Illegal: TRAP at T+1, FLUSH from T+2.
- All state and counters registered; only MEM ack strobes and `instr_ready_o` are combinational.

## Test plan
- Reset then ALU op (class 0) at cycle 1 → `regfile_wr_en_o`=`pc_en_o`=1 at cycle 2, `instr_ready_o`=1 at cycle 3.
- BRANCH taken, FLUSH_CYCLES=2 → B_ST + `pc_en_o` one cycle, `flush_o` exactly 2 cycles, IDLE after; not-taken → PC_ST, no flush.
- LOAD, ack in 3rd MEM cycle → `l1d_req_o` 3 cycles, `l1d_wr_en_o`=0, `regfile_wr_en_o`=1 and `wb_sel_o`=1 in ack cycle only; STORE same with `l1d_wr_en_o`=1, no regfile write.
- STORE, MEM_TIMEOUT=16, no ack → TRAP after 16 MEM cycles, `trap_o` 1 cycle, `trap_cause_o`=1, TRAP_ST; repeat with ack in 16th cycle → no trap.
- op_class_i=6 → TRAP next cycle, cause 0, then FLUSH_CYCLES of flush; valid during FLUSH not accepted.
- Assert `rst_i` mid-MEM with `l1d_req_o` high → all outputs 0 immediately (async), IDLE after release, `trap_cause_o`=0.

Source files
------------

// File: rtl/kamus_ctrl_fsm.sv
// Purpose: sequenced control FSM for kamus-v; drives PC/writeback/L1D/regfile strobes.
// Latency: ALU/not-taken 1 cycle, redirects 1+FLUSH_CYCLES, memory 1+k (trap after MEM_TIMEOUT).
// Backpressure: instr_ready_o high only in IDLE outside reset; valid elsewhere is ignored.
module kamus_ctrl_fsm #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       instr_valid_i,
    output logic       instr_ready_o,
    input  logic [2:0] op_class_i,
    input  logic       branch_taken_i,
    input  logic       mem_ack_i,
    output logic [1:0] instr_addr_state_o,
    output logic       wb_sel_o,
    output logic       l1d_req_o,
    output logic       l1d_wr_en_o,
    output logic       regfile_wr_en_o,
    output logic       pc_en_o,
    output logic       flush_o,
    output logic       trap_o,
    output logic       trap_cause_o,
    output logic [2:0] state_o
);

    localparam int MCW = $clog2(MEM_TIMEOUT + 1);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [MCW-1:0] MEM_LAST   = MCW'(MEM_TIMEOUT - 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JUMP   = 3'd4;

    localparam logic [1:0] PC_ST   = 2'd0;
    localparam logic [1:0] B_ST    = 2'd1;
    localparam logic [1:0] J_ST    = 2'd2;
    localparam logic [1:0] TRAP_ST = 2'd3;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    localparam logic CAUSE_ILLEGAL = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_TRAP  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [MCW-1:0] mem_cnt_q, mem_cnt_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [2:0]     op_q, op_d;
    logic           taken_q, taken_d;
    logic           cause_q, cause_d;
    logic           accept;

    // Ready is forced low during reset so nothing is accepted while rst_i is high.
    assign instr_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept        = instr_valid_i && instr_ready_o;
    assign trap_cause_o  = cause_q;
    assign state_o       = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
            op_q        <= CLS_ALU;
            taken_q     <= 1'b0;
            cause_q     <= CAUSE_ILLEGAL;
        end else begin
            state_q     <= state_d;
            mem_cnt_q   <= mem_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            op_q        <= op_d;
            taken_q     <= taken_d;
            cause_q     <= cause_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        mem_cnt_d          = mem_cnt_q;
        flush_cnt_d        = flush_cnt_q;
        op_d               = op_q;
        taken_d            = taken_q;
        cause_d            = cause_q;
        instr_addr_state_o = PC_ST;
        wb_sel_o           = WB_ALU;
        l1d_req_o          = 1'b0;
        l1d_wr_en_o        = 1'b0;
        regfile_wr_en_o    = 1'b0;
        pc_en_o            = 1'b0;
        flush_o            = 1'b0;
        trap_o             = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = op_class_i;
                    taken_d = branch_taken_i;
                    if (op_class_i > CLS_JUMP) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = ST_TRAP;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                flush_cnt_d = '0;
                mem_cnt_d   = '0;
                unique case (op_q)
                    CLS_ALU: begin
                        regfile_wr_en_o = 1'b1;
                        pc_en_o         = 1'b1;
                        state_d         = ST_IDLE;
                    end
                    CLS_JUMP: begin
                        regfile_wr_en_o    = 1'b1;
                        pc_en_o            = 1'b1;
                        instr_addr_state_o = J_ST;
                        state_d            = ST_FLUSH;
                    end
                    CLS_BRANCH: begin
                        pc_en_o = 1'b1;
                        if (taken_q) begin
                            instr_addr_state_o = B_ST;
                            state_d            = ST_FLUSH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_d = ST_MEM;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            ST_MEM: begin
                l1d_req_o   = 1'b1;
                l1d_wr_en_o = (op_q == CLS_STORE);
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack_i) begin
                    pc_en_o = 1'b1;
                    if (op_q == CLS_LOAD) begin
                        regfile_wr_en_o = 1'b1;
                        wb_sel_o        = WB_MEM;
                    end
                    state_d = ST_IDLE;
                end else if (mem_cnt_q == MEM_LAST) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = ST_TRAP;
                end else begin
                    mem_cnt_d = mem_cnt_q + MCW'(1);
                end
            end

            ST_FLUSH: begin
                flush_o = 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FCW'(1);
                end
            end

            ST_TRAP: begin
                trap_o             = 1'b1;
                flush_o            = 1'b1;
                pc_en_o            = 1'b1;
                instr_addr_state_o = TRAP_ST;
                flush_cnt_d        = '0;
                state_d            = ST_FLUSH;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_kamus_ctrl_fsm.sv
// Directed bench for kamus_ctrl_fsm (MEM_TIMEOUT=16, FLUSH_CYCLES=2).
module tb_kamus_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       instr_valid_i;
    logic       instr_ready_o;
    logic [2:0] op_class_i;
    logic       branch_taken_i;
    logic       mem_ack_i;
    logic [1:0] instr_addr_state_o;
    logic       wb_sel_o;
    logic       l1d_req_o;
    logic       l1d_wr_en_o;
    logic       regfile_wr_en_o;
    logic       pc_en_o;
    logic       flush_o;
    logic       trap_o;
    logic       trap_cause_o;
    logic [2:0] state_o;

    int cmps  = 0;
    int fails = 0;
    logic cz = 1'b0;
    logic [13:0] obs, exp;

    kamus_ctrl_fsm #(.MEM_TIMEOUT(16), .FLUSH_CYCLES(2)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .instr_valid_i      (instr_valid_i),
        .instr_ready_o      (instr_ready_o),
        .op_class_i         (op_class_i),
        .branch_taken_i     (branch_taken_i),
        .mem_ack_i          (mem_ack_i),
        .instr_addr_state_o (instr_addr_state_o),
        .wb_sel_o           (wb_sel_o),
        .l1d_req_o          (l1d_req_o),
        .l1d_wr_en_o        (l1d_wr_en_o),
        .regfile_wr_en_o    (regfile_wr_en_o),
        .pc_en_o            (pc_en_o),
        .flush_o            (flush_o),
        .trap_o             (trap_o),
        .trap_cause_o       (trap_cause_o),
        .state_o            (state_o)
    );

    always #5 clk = ~clk;

    assign obs = {instr_ready_o, instr_addr_state_o, wb_sel_o, l1d_req_o, l1d_wr_en_o,
                  regfile_wr_en_o, pc_en_o, flush_o, trap_o, trap_cause_o, state_o};

    // Field order: ready, addr, wb, req, wr, rf, pc, flush, trap, cause, state
    function automatic logic [13:0] pk(input logic rdy, input logic [1:0] addr, input logic wb,
                                       input logic req, input logic wr, input logic rf,
                                       input logic pc, input logic fl, input logic tr,
                                       input logic cause, input logic [2:0] st);
        return {rdy, addr, wb, req, wr, rf, pc, fl, tr, cause, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic taken);
        instr_valid_i  = 1'b1;
        op_class_i     = op;
        branch_taken_i = taken;
        #1;
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, cz, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL issue_ready op=%0d got=%b exp=%b", op, obs, exp); end
        tick();
        instr_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; instr_valid_i = 1'b1; op_class_i = 3'd0; branch_taken_i = 1'b0; mem_ack_i = 1'b0;
        tick(); tick();
        exp = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL reset_hold got=%b exp=%b", obs, exp); end
        instr_valid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL reset_release got=%b exp=%b", obs, exp); end
        tick();
    endtask

    task automatic test_alu();
        mem_ack_i = 1'b1;
        issue(3'd0, 1'b0);
        exp = pk(0, 0, 0, 0, 0, 1, 1, 0, 0, cz, 1); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL alu_exec got=%b exp=%b", obs, exp); end
        tick();
        mem_ack_i = 1'b0;
        #1;
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, cz, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL alu_idle got=%b exp=%b", obs, exp); end
    endtask

    task automatic test_redirect(input logic [2:0] op, input logic [1:0] addr, input logic rf);
        issue(op, 1'b1);
        exp = pk(0, addr, 0, 0, 0, rf, 1, 0, 0, cz, 1); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL redir_exec op=%0d got=%b exp=%b", op, obs, exp); end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = pk(0, 0, 0, 0, 0, 0, 0, 1, 0, cz, 3); cmps++;
            if (obs !== exp) begin fails++; $display("FAIL redir_flush%0d op=%0d got=%b exp=%b", i, op, obs, exp); end
        end
        tick();
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, cz, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL redir_idle op=%0d got=%b exp=%b", op, obs, exp); end
    endtask

    task automatic test_branch_not_taken();
        issue(3'd3, 1'b0);
        exp = pk(0, 0, 0, 0, 0, 0, 1, 0, 0, cz, 1); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL bnt_exec got=%b exp=%b", obs, exp); end
        tick();
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, cz, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL bnt_idle got=%b exp=%b", obs, exp); end
    endtask

    // Memory op with ack in MEM cycle ack_k (0 = never ack).
    task automatic test_mem(input logic store, input int ack_k);
        issue(store ? 3'd2 : 3'd1, 1'b0);
        exp = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, cz, 1); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL mem_exec st=%0d got=%b exp=%b", store, obs, exp); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == ack_k) begin
                mem_ack_i = 1'b1;
                #1;
                exp = pk(0, 0, !store, 1, store, !store, 1, 0, 0, cz, 2); cmps++;
                if (obs !== exp) begin fails++; $display("FAIL mem_ack st=%0d k=%0d got=%b exp=%b", store, k, obs, exp); end
                break;
            end
            exp = pk(0, 0, 0, 1, store, 0, 0, 0, 0, cz, 2); cmps++;
            if (obs !== exp) begin fails++; $display("FAIL mem_wait st=%0d k=%0d got=%b exp=%b", store, k, obs, exp); end
        end
        tick();
        mem_ack_i = 1'b0;
        #1;
        if (ack_k == 0) begin
            cz = 1'b1;
            exp = pk(0, 3, 0, 0, 0, 0, 1, 1, 1, 1, 4); cmps++;
            if (obs !== exp) begin fails++; $display("FAIL mem_trap got=%b exp=%b", obs, exp); end
            for (int i = 0; i < 2; i++) begin
                tick();
                exp = pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3); cmps++;
                if (obs !== exp) begin fails++; $display("FAIL trap_flush%0d got=%b exp=%b", i, obs, exp); end
            end
            tick();
        end
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, cz, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL mem_idle st=%0d k=%0d got=%b exp=%b", store, ack_k, obs, exp); end
    endtask

    task automatic test_illegal();
        issue(3'd6, 1'b0);
        cz = 1'b0;
        exp = pk(0, 3, 0, 0, 0, 0, 1, 1, 1, 0, 4); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL ill_trap got=%b exp=%b", obs, exp); end
        instr_valid_i = 1'b1;
        op_class_i    = 3'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3); cmps++;
            if (obs !== exp) begin fails++; $display("FAIL ill_flush%0d got=%b exp=%b", i, obs, exp); end
        end
        tick();
        instr_valid_i = 1'b0;
        #1;
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL ill_idle got=%b exp=%b", obs, exp); end
        tick();
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL ill_stay_idle got=%b exp=%b", obs, exp); end
    endtask

    task automatic test_reset_mid_mem();
        issue(3'd1, 1'b0);
        tick();
        exp = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, cz, 2); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL rst_pre got=%b exp=%b", obs, exp); end
        #2;
        rst_i = 1'b1;
        #1;
        cz = 1'b0;
        exp = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL rst_async got=%b exp=%b", obs, exp); end
        tick();
        rst_i = 1'b0;
        #1;
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL rst_after got=%b exp=%b", obs, exp); end
        tick();
        exp = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cmps++;
        if (obs !== exp) begin fails++; $display("FAIL rst_settled got=%b exp=%b", obs, exp); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_redirect(3'd3, 2'd1, 1'b0);
        test_branch_not_taken();
        test_redirect(3'd4, 2'd2, 1'b1);
        test_mem(1'b0, 3);
        test_mem(1'b1, 3);
        test_illegal();
        test_mem(1'b1, 0);
        test_mem(1'b1, 16);
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end

endmodule
